// File: rtl/xor3_pkg.sv
// Shared definitions for the registered 3-operand XOR unit.
// Widths are carried as a full 64-bit word and narrowed at the use site.
package xor3_pkg;

    localparam int XOR3_DEFAULT_WIDTH = 1;
    localparam int XOR3_MAX_WIDTH     = 64;

    typedef logic [XOR3_MAX_WIDTH-1:0] xor3_word_t;

    function automatic xor3_word_t xor3(
        input xor3_word_t a,
        input xor3_word_t b,
        input xor3_word_t c
    );
        return a ^ b ^ c;
    endfunction

endpackage

// File: rtl/xor3_core.sv
// Combinational WIDTH-bit 3-input XOR with reduction parity.
// Operands are zero-extended so unused upper bits never affect parity.
module xor3_core
    import xor3_pkg::*;
#(
    parameter int WIDTH = XOR3_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] y_o,
    output logic             parity_o
);

    xor3_word_t a_ext;
    xor3_word_t b_ext;
    xor3_word_t c_ext;
    xor3_word_t full;

    // Widen operands to the package word and combine them.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        c_ext = '0;
        a_ext[WIDTH-1:0] = a_i;
        b_ext[WIDTH-1:0] = b_i;
        c_ext[WIDTH-1:0] = c_i;
        full = xor3(a_ext, b_ext, c_ext);
    end

    assign y_o      = full[WIDTH-1:0];
    assign parity_o = ^full;

endmodule

// File: rtl/xor3_parity_unit.sv
// Registered 3-operand XOR with result parity and running XOR accumulator.
// One-cycle latency, no backpressure, synchronous active-high reset.
module xor3_parity_unit
    import xor3_pkg::*;
#(
    parameter int WIDTH = XOR3_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             parity,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] res;
    logic             res_par;

    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             vld_q;
    logic             vld_d;
    logic             par_q;
    logic             par_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;

    xor3_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (x1),
        .b_i      (x2),
        .c_i      (x3),
        .y_o      (res),
        .parity_o (res_par)
    );

    // Next state: capture result on a valid beat, otherwise hold.
    // Operands are only selected when in_valid is set, so garbage
    // on x1..x3 during idle cycles cannot leak into state.
    always_comb begin
        y_d   = y_q;
        par_d = par_q;
        vld_d = in_valid;
        acc_d = acc_q;
        if (in_valid) begin
            y_d   = res;
            par_d = res_par;
        end
        unique case ({acc_clr, in_valid})
            2'b11:   acc_d = res;
            2'b10:   acc_d = '0;
            2'b01:   acc_d = acc_q ^ res;
            default: acc_d = acc_q;
        endcase
    end

    // State registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            vld_q <= 1'b0;
            par_q <= 1'b0;
            acc_q <= '0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
            par_q <= par_d;
            acc_q <= acc_d;
        end
    end

    assign y       = y_q;
    assign y_valid = vld_q;
    assign parity  = par_q;
    assign acc     = acc_q;

endmodule

// File: tb/tb_xor3_parity_unit.sv
// Scoreboard bench for xor3_parity_unit at WIDTH=1 and WIDTH=8.
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_xor3_parity_unit;

    typedef struct {
        string      tag;
        logic       v;
        logic [7:0] y;
        logic       p;
        logic [7:0] acc;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       a_v;
    logic       a_x1;
    logic       a_x2;
    logic       a_x3;
    logic       a_clr;
    logic       a_y;
    logic       a_yv;
    logic       a_par;
    logic       a_acc;

    logic       b_v;
    logic [7:0] b_x1;
    logic [7:0] b_x2;
    logic [7:0] b_x3;
    logic       b_clr;
    logic [7:0] b_y;
    logic       b_yv;
    logic       b_par;
    logic [7:0] b_acc;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    xor3_parity_unit #(.WIDTH(1)) u_w1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_v),
        .x1       (a_x1),
        .x2       (a_x2),
        .x3       (a_x3),
        .acc_clr  (a_clr),
        .y        (a_y),
        .y_valid  (a_yv),
        .parity   (a_par),
        .acc      (a_acc)
    );

    xor3_parity_unit #(.WIDTH(8)) u_w8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_v),
        .x1       (b_x1),
        .x2       (b_x2),
        .x3       (b_x3),
        .acc_clr  (b_clr),
        .y        (b_y),
        .y_valid  (b_yv),
        .parity   (b_par),
        .acc      (b_acc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic cmp(string name, logic [7:0] got, logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: compare each queued expectation just after its edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            n_vec++;
            cmp({e.tag, ".w1.vld"}, {7'b0, a_yv}, {7'b0, e.v});
            cmp({e.tag, ".w1.y"}, {7'b0, a_y}, e.y);
            cmp({e.tag, ".w1.par"}, {7'b0, a_par}, {7'b0, e.p});
            cmp({e.tag, ".w1.acc"}, {7'b0, a_acc}, e.acc);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            n_vec++;
            cmp({e.tag, ".w8.vld"}, {7'b0, b_yv}, {7'b0, e.v});
            cmp({e.tag, ".w8.y"}, b_y, e.y);
            cmp({e.tag, ".w8.par"}, {7'b0, b_par}, {7'b0, e.p});
            cmp({e.tag, ".w8.acc"}, b_acc, e.acc);
        end
    end

    task automatic tick();
        @(negedge clk);
        rst   = 1'b0;
        a_v   = 1'b0;
        a_clr = 1'b0;
        b_v   = 1'b0;
        b_clr = 1'b0;
    endtask

    task automatic exp_a(string tag, logic v, logic [7:0] y,
                         logic p, logic [7:0] acc);
        exp_t e;
        e.tag = tag; e.v = v; e.y = y; e.p = p; e.acc = acc;
        q_a.push_back(e);
    endtask

    task automatic exp_b(string tag, logic v, logic [7:0] y,
                         logic p, logic [7:0] acc);
        exp_t e;
        e.tag = tag; e.v = v; e.y = y; e.p = p; e.acc = acc;
        q_b.push_back(e);
    endtask

    task automatic drv_b(logic v, logic [7:0] x1, logic [7:0] x2,
                         logic [7:0] x3, logic clr);
        b_v = v; b_x1 = x1; b_x2 = x2; b_x3 = x3; b_clr = clr;
    endtask

    // Truth table for (x3,x2,x1)=i: y bit i, running acc bit i.
    logic [7:0] tt_y   = 8'b1001_0110;
    logic [7:0] tt_acc = 8'b0111_0010;

    initial begin
        rst = 1'b1;
        a_v = 0; a_x1 = 0; a_x2 = 0; a_x3 = 0; a_clr = 0;
        b_v = 0; b_x1 = 0; b_x2 = 0; b_x3 = 0; b_clr = 0;

        // Reset held two cycles with random valid beats.
        for (int i = 0; i < 2; i++) begin
            tick();
            rst   = 1'b1;
            a_v   = 1'b1;
            a_x1  = 1'($urandom);
            a_x2  = 1'($urandom);
            a_x3  = 1'($urandom);
            a_clr = 1'($urandom);
            drv_b(1'b1, 8'($urandom), 8'($urandom),
                  8'($urandom), 1'($urandom));
            exp_a("rst", 0, 8'h00, 0, 8'h00);
            exp_b("rst", 0, 8'h00, 0, 8'h00);
        end

        // WIDTH=1 truth table.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] s;
            s = 3'(i);
            tick();
            a_v  = 1'b1;
            a_x1 = s[0];
            a_x2 = s[1];
            a_x3 = s[2];
            exp_a($sformatf("tt%0d", i), 1, {7'b0, tt_y[i]},
                  tt_y[i], {7'b0, tt_acc[i]});
        end

        // Idle with operands all ones: nothing moves.
        for (int i = 0; i < 3; i++) begin
            tick();
            a_x1 = 1'b1;
            a_x2 = 1'b1;
            a_x3 = 1'b1;
            exp_a("hold", 0, 8'h01, 1, 8'h00);
        end

        // WIDTH=8 accumulator sequence.
        tick();
        drv_b(1, 8'h0F, 8'hF0, 8'h00, 0);
        exp_b("acc0", 1, 8'hFF, 0, 8'hFF);
        tick();
        drv_b(1, 8'hFF, 8'h00, 8'h01, 0);
        exp_b("acc1", 1, 8'hFE, 1, 8'h01);
        tick();
        drv_b(1, 8'h12, 8'h34, 8'h56, 0);
        exp_b("acc2", 1, 8'h70, 1, 8'h71);

        // Clear together with a beat, then clear alone.
        tick();
        drv_b(1, 8'h01, 8'h02, 8'h04, 1);
        exp_b("clrv", 1, 8'h07, 1, 8'h07);
        tick();
        drv_b(0, 8'hA5, 8'h5A, 8'h3C, 1);
        exp_b("clr", 0, 8'h07, 1, 8'h00);

        // Reset on the same edge as a valid beat.
        tick();
        rst = 1'b1;
        a_v = 1'b1; a_x1 = 1; a_x2 = 0; a_x3 = 0;
        drv_b(1, 8'hAA, 8'h55, 8'h00, 0);
        exp_a("rstmid", 0, 8'h00, 0, 8'h00);
        exp_b("rstmid", 0, 8'h00, 0, 8'h00);

        // First beats after reset.
        tick();
        a_v = 1'b1; a_x1 = 1; a_x2 = 0; a_x3 = 0;
        drv_b(1, 8'hAA, 8'h55, 8'h0F, 0);
        exp_a("post", 1, 8'h01, 1, 8'h01);
        exp_b("post", 1, 8'hF0, 0, 8'hF0);
        tick();
        exp_a("post_idle", 0, 8'h01, 1, 8'h01);
        exp_b("post_idle", 0, 8'hF0, 0, 8'hF0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge clk);
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending want 0",
                     q_a.size() + q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule
